// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_chain stage-register backbone.
//   - stage_idx_w(): width of a stage index (at least 1 bit)
//   - PERF_CNT_W:    width of the optional performance counters
//   - RST_PAYLOAD_BIT: value every payload bit takes on reset, flush or bubble
package pipe_pkg;

    localparam int   PERF_CNT_W      = 32;
    localparam logic RST_PAYLOAD_BIT = 1'b0;

    function automatic int stage_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+payload slot of the pipe_chain.
// Update priority on each rising edge: flush, then hold, then load.
// A load from a source stage that is itself held becomes a bubble, so an
// item can never be in two stages at once.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-low reset (clears valid and payload)
//   flush_i      turn this stage into a bubble
//   hold_i       keep current contents
//   src_valid_i  valid bit of the upstream source
//   src_data_i   payload of the upstream source
//   src_held_i   upstream source is holding its item this cycle
//   valid_o      stage valid bit
//   data_o       stage payload
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic             src_valid_i,
    input  logic [WIDTH-1:0] src_data_i,
    input  logic             src_held_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = {WIDTH{RST_PAYLOAD_BIT}};
        end else if (!hold_i) begin
            if (src_held_i) begin
                // Source keeps its item, so only a bubble moves forward.
                valid_d = 1'b0;
                data_d  = {WIDTH{RST_PAYLOAD_BIT}};
            end else begin
                valid_d = src_valid_i;
                data_d  = src_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{RST_PAYLOAD_BIT}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// Elastic pipeline-register chain: DEPTH stages of WIDTH-bit payload with
// per-stage stall/flush, bubble collapsing and valid/ready at both ends.
// Stage 0 is the youngest, stage DEPTH-1 the oldest and drives the output.
// Optional build macro PIPE_CHAIN_PERF_EN adds perf_xfer_o/perf_stall_o.
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-low reset
//   in_valid_i     upstream item present
//   in_data_i      upstream payload
//   in_ready_o     stage 0 accepts this cycle
//   out_valid_o    oldest stage holds a valid item
//   out_data_o     oldest stage payload
//   out_ready_i    downstream consumes the item this cycle
//   stall_i        bit k holds stage k
//   flush_i        bit k makes stage k a bubble at the next edge
//   stage_valid_o  valid bit of each stage
//   stage_data_o   payload of stage k at [k*WIDTH +: WIDTH]
//   perf_xfer_o    (PIPE_CHAIN_PERF_EN) number of output transfers, wrapping
//   perf_stall_o   (PIPE_CHAIN_PERF_EN) cycles with input presented but refused
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    input  logic [WIDTH-1:0]       in_data_i,
    output logic                   in_ready_o,
    output logic                   out_valid_o,
    output logic [WIDTH-1:0]       out_data_o,
    input  logic                   out_ready_i,
    input  logic [DEPTH-1:0]       stall_i,
    input  logic [DEPTH-1:0]       flush_i,
    output logic [DEPTH-1:0]       stage_valid_o,
    output logic [DEPTH*WIDTH-1:0] stage_data_o
`ifdef PIPE_CHAIN_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]  perf_xfer_o,
    output logic [PERF_CNT_W-1:0]  perf_stall_o
`endif
);

    localparam int               IDX_W   = stage_idx_w(DEPTH);
    localparam logic [IDX_W-1:0] OUT_IDX = IDX_W'(DEPTH - 1);

    logic [DEPTH-1:0]            stage_v;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;
    logic [DEPTH-1:0]            hold;

    // Hold propagates upstream only through valid stages, so an empty stage
    // always absorbs the item behind it and bubbles get squeezed out.
    always_comb begin
        hold          = '0;
        hold[DEPTH-1] = stall_i[DEPTH-1] | (stage_v[DEPTH-1] & ~out_ready_i);
        for (int k = DEPTH - 2; k >= 0; k--) begin
            hold[k] = stall_i[k] | (stage_v[k] & hold[k+1]);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic             src_held;

        if (k == 0) begin : g_head
            assign src_valid = in_valid_i;
            assign src_data  = in_data_i;
            assign src_held  = 1'b0;
        end else begin : g_body
            assign src_valid = stage_v[k-1];
            assign src_data  = stage_d[k-1];
            assign src_held  = hold[k-1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i[k]),
            .hold_i     (hold[k]),
            .src_valid_i(src_valid),
            .src_data_i (src_data),
            .src_held_i (src_held),
            .valid_o    (stage_v[k]),
            .data_o     (stage_d[k])
        );
    end

    assign in_ready_o    = ~hold[0];
    assign out_valid_o   = stage_v[OUT_IDX];
    assign out_data_o    = stage_d[OUT_IDX];
    assign stage_valid_o = stage_v;
    assign stage_data_o  = stage_d;

`ifdef PIPE_CHAIN_PERF_EN
    logic                  out_xfer;
    logic                  in_blocked;
    logic [PERF_CNT_W-1:0] perf_xfer_q,  perf_xfer_d;
    logic [PERF_CNT_W-1:0] perf_stall_q, perf_stall_d;

    assign out_xfer   = out_valid_o & out_ready_i & ~stall_i[DEPTH-1];
    assign in_blocked = in_valid_i & ~in_ready_o;

    // Counters wrap naturally at the counter width.
    always_comb begin
        perf_xfer_d  = perf_xfer_q  + {{(PERF_CNT_W-1){1'b0}}, out_xfer};
        perf_stall_d = perf_stall_q + {{(PERF_CNT_W-1){1'b0}}, in_blocked};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_xfer_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_xfer_q  <= perf_xfer_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_xfer_o  = perf_xfer_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain (DEPTH=4, WIDTH=32): directed steps with
// a scoreboard queue filled on input transfers and drained on output transfers.
module tb_pipe_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    localparam logic [31:0] D_A = 32'hA000_000A;
    localparam logic [31:0] D_B = 32'hB000_000B;
    localparam logic [31:0] D_C = 32'hC000_000C;
    localparam logic [31:0] D_D = 32'hD000_000D;
    localparam logic [31:0] D_E = 32'hE000_000E;
    localparam logic [31:0] D_X = 32'h5A5A_1234;
    localparam logic [31:0] D_F = 32'hF000_000F;
    localparam logic [31:0] D_G = 32'h6000_0006;
    localparam logic [31:0] D_H = 32'h7000_0007;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   in_valid_i;
    logic [WIDTH-1:0]       in_data_i;
    logic                   in_ready_o;
    logic                   out_valid_o;
    logic [WIDTH-1:0]       out_data_o;
    logic                   out_ready_i;
    logic [DEPTH-1:0]       stall_i;
    logic [DEPTH-1:0]       flush_i;
    logic [DEPTH-1:0]       stage_valid_o;
    logic [DEPTH*WIDTH-1:0] stage_data_o;
`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0]            perf_xfer_o;
    logic [31:0]            perf_stall_o;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb_q[$];
    logic [31:0] sb_exp;
    logic [31:0] fill_vals [4];

    always #5 clk_i = ~clk_i;

    pipe_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .stage_valid_o(stage_valid_o),
        .stage_data_o (stage_data_o)
`ifdef PIPE_CHAIN_PERF_EN
        ,
        .perf_xfer_o  (perf_xfer_o),
        .perf_stall_o (perf_stall_o)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: both handshakes are evaluated mid-cycle, ahead of the edge
    // that performs them.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            if (out_valid_o && out_ready_i && !stall_i[DEPTH-1]) begin
                check("sb_nonempty", 128'(sb_q.size() > 0), 128'h1);
                if (sb_q.size() > 0) begin
                    sb_exp = sb_q.pop_front();
                    check("sb_out_data", 128'(out_data_o), 128'(sb_exp));
                end
            end
            if (in_valid_i && in_ready_o) sb_q.push_back(in_data_i);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fill_vals = '{D_A, D_B, D_C, D_D};
        rst_i       = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        stall_i     = '0;
        flush_i     = '0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid",   128'(out_valid_o),   128'h0);
        check("rst_out_data",    128'(out_data_o),    128'h0);
        check("rst_stage_valid", 128'(stage_valid_o), 128'h0);
        check("rst_stage_data",  128'(stage_data_o),  128'h0);
        check("rst_in_ready",    128'(in_ready_o),    128'h1);
        rst_i = 1'b1;
        tick();
        check("release_idle_valid", 128'(stage_valid_o), 128'h0);
        check("release_in_ready",   128'(in_ready_o),    128'h1);

        // Streaming 0x11, 0x22, 0x33
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h11;
        tick();
        in_data_i = 32'h22;
        tick();
        in_data_i = 32'h33;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        check("stream_fill_valid", 128'(stage_valid_o), 128'h7);
        check("stream_not_yet",    128'(out_valid_o),   128'h0);
        tick();
        check("stream_v0", 128'(out_valid_o), 128'h1);
        check("stream_d0", 128'(out_data_o),  128'h11);
        tick();
        check("stream_d1", 128'(out_data_o),  128'h22);
        tick();
        check("stream_d2", 128'(out_data_o),  128'h33);
        tick();
        check("stream_drop", 128'(out_valid_o), 128'h0);

        // Fill the chain with out_ready low: stage3..0 = A,B,C,D
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data_i = fill_vals[i];
            tick();
        end
        in_valid_i = 1'b0;
        in_data_i  = '0;
        check("full_valid",    128'(stage_valid_o), 128'hF);
        check("full_data",     128'(stage_data_o),  {D_A, D_B, D_C, D_D});
        check("full_in_ready", 128'(in_ready_o),    128'h0);

        // Stall stage 1 for two cycles while downstream drains
        stall_i     = 4'b0010;
        out_ready_i = 1'b1;
        #1;
        check("stall_in_ready_0", 128'(in_ready_o), 128'h0);
        tick();
        check("stall_valid_1",    128'(stage_valid_o), 128'hB);
        check("stall_out_1",      128'(out_data_o),    128'(D_B));
        check("stall_in_ready_1", 128'(in_ready_o),    128'h0);
        tick();
        check("stall_valid_2",    128'(stage_valid_o), 128'h3);
        check("stall_data_2",     128'(stage_data_o),  {32'h0, 32'h0, D_C, D_D});
        check("stall_in_ready_2", 128'(in_ready_o),    128'h0);
        stall_i = '0;
        repeat (4) tick();
        check("drain_empty", 128'(stage_valid_o), 128'h0);

        // Bubble squeeze: stage3=E, stage0=X, middle empty, output blocked
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = D_E;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        tick();
        tick();
        in_valid_i = 1'b1;
        in_data_i  = D_X;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        check("squeeze_pre_valid", 128'(stage_valid_o), 128'h9);
        check("squeeze_in_ready",  128'(in_ready_o),    128'h1);
        in_valid_i = 1'b1;
        in_data_i  = 32'h55;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        check("squeeze_valid", 128'(stage_valid_o), 128'hB);
        check("squeeze_data",  128'(stage_data_o),  {D_E, 32'h0, D_X, 32'h55});
        tick();
        check("squeeze_valid_2", 128'(stage_valid_o), 128'hE);
        tick();
        check("held_s0_empty_valid", 128'(stage_valid_o), 128'hE);
        check("held_s0_empty_data",  128'(stage_data_o),  {D_E, D_X, 32'h55, 32'h0});
        check("held_s0_empty_ready", 128'(in_ready_o),    128'h1);
        in_valid_i = 1'b1;
        in_data_i  = 32'h66;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        check("full2_valid",    128'(stage_valid_o), 128'hF);
        check("full2_in_ready", 128'(in_ready_o),    128'h0);

        // Flush stages 0-1 while stage 1 is stalled; 0x55 and 0x66 are lost
        out_ready_i = 1'b1;
        flush_i     = 4'b0011;
        stall_i     = 4'b0010;
        void'(sb_q.pop_back());
        void'(sb_q.pop_back());
        tick();
        flush_i = '0;
        stall_i = '0;
        check("flush_valid",   128'(stage_valid_o),         128'h8);
        check("flush_low_64",  128'(stage_data_o[63:0]),    128'h0);
        check("flush_high_64", 128'(stage_data_o[127:64]),  128'({D_X, 32'h0}));
        tick();
        tick();
        check("flush_drained", 128'(out_valid_o), 128'h0);

        // Asynchronous reset between edges with items in flight
        in_valid_i = 1'b1;
        in_data_i  = D_F;
        tick();
        in_data_i = D_G;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        check("arst_pre_valid", 128'(stage_valid_o), 128'h3);
        #1;
        rst_i = 1'b0;
        #1;
        check("arst_stage_valid", 128'(stage_valid_o), 128'h0);
        check("arst_stage_data",  128'(stage_data_o),  128'h0);
        check("arst_out_valid",   128'(out_valid_o),   128'h0);
        check("arst_in_ready",    128'(in_ready_o),    128'h1);
        sb_q.delete();
        #1;
        rst_i = 1'b1;
        tick();
        check("arst_release_idle", 128'(stage_valid_o), 128'h0);
        in_valid_i = 1'b1;
        in_data_i  = D_H;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        tick();
        tick();
        check("arst_lat_early", 128'(out_valid_o), 128'h0);
        tick();
        check("arst_lat_valid", 128'(out_valid_o), 128'h1);
        check("arst_lat_data",  128'(out_data_o),  128'(D_H));
        tick();
        check("arst_lat_gone",  128'(out_valid_o), 128'h0);

`ifdef PIPE_CHAIN_PERF_EN
        // Performance counters: wrap of the transfer count, blocked-input count
        check("perf_stall_clear", 128'(perf_stall_o), 128'h0);
        force dut.perf_xfer_q = 32'hFFFF_FFFE;
        #1;
        release dut.perf_xfer_q;
        #1;
        check("perf_xfer_preload", 128'(perf_xfer_o), 128'hFFFF_FFFE);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data_i = 32'h700 + i;
            tick();
        end
        in_valid_i = 1'b0;
        in_data_i  = '0;
        repeat (4) tick();
        check("perf_xfer_wrap", 128'(perf_xfer_o), 128'h1);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data_i = 32'h800 + i;
            tick();
        end
        in_data_i = 32'h900;
        repeat (5) tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
        check("perf_stall_count", 128'(perf_stall_o), 128'h5);
        out_ready_i = 1'b1;
        repeat (5) tick();
`endif

        tick();
        tick();
        check("sb_empty", 128'(sb_q.size()), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
